// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Width of the bit counter for a given operand width.
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// Combinational 1-bit full adder cell.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ cin;
    assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder sequencing operands through one fa_cell.
// Optional two's-complement overflow output enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_width(WIDTH);

    state_e           state;
    state_e           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] s_sr;
    logic [WIDTH-1:0] s_nxt;
    logic             c_ff;
    logic [CW-1:0]    cnt;
    logic             s_c;
    logic             co_c;
    logic             load_c;
    logic             last_c;

    fa_cell u_fa (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .cin (c_ff),
        .s   (s_c),
        .co  (co_c)
    );

    // New sum bit enters at the MSB; after WIDTH shifts s_nxt holds the full sum.
    assign s_nxt = (s_sr >> 1) | {s_c, {(WIDTH-1){1'b0}}};

    always_comb begin
        state_d = state;
        load_c  = 1'b0;
        last_c  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load_c  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH-1)) begin
                    last_c  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            busy  <= (state_d == SHIFT);
            done  <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr  <= '0;
            b_sr  <= '0;
            s_sr  <= '0;
            c_ff  <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else if (load_c) begin
            a_sr <= a;
            b_sr <= b;
            s_sr <= '0;
            c_ff <= cin;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            s_sr <= s_nxt;
            c_ff <= co_c;
            cnt  <= cnt + CW'(1);
            if (last_c) begin
                sum   <= s_nxt;
                carry <= co_c;
`ifdef SERIAL_ADDER_OVF_EN
                // c_ff is the carry into the MSB on the final bit.
                ovf   <= c_ff ^ co_c;
`endif
            end
        end
    end

endmodule
